// File: rtl/reaction_timer_core_if.sv
// Signal bundle between the reaction timer core and its game-side environment.
// The master side drives the timebase and buttons; the slave side is the core.
interface reaction_timer_core_if;
  logic        tick_in;
  logic        start_btn;
  logic        react_btn;
  logic        led_go;
  logic        busy;
  logic [13:0] result_ms;
  logic        result_valid;
  logic        false_start;
  logic        overflow;
  logic [13:0] best_ms;

  modport master (
    output tick_in, start_btn, react_btn,
    input  led_go, busy, result_ms, result_valid, false_start, overflow, best_ms
  );

  modport slave (
    input  tick_in, start_btn, react_btn,
    output led_go, busy, result_ms, result_valid, false_start, overflow, best_ms
  );
endinterface

// File: rtl/reaction_timer_core.sv
// Reaction-test round controller: random wait, GO, ms count until react press.
// Optional best-score tracking is enabled by defining BEST_SCORE_EN.
module reaction_timer_core #(
  parameter int          MIN_DELAY_TICKS = 1000,
  parameter int          DELAY_BITS      = 12,
  parameter int          MAX_MS          = 9999,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic                  cin,
  input  logic                  rst,
  reaction_timer_core_if.slave  bus
);

  localparam int          DW    = $clog2(MIN_DELAY_TICKS + (1 << DELAY_BITS)) + 1;
  localparam logic [13:0] MAX_C = 14'(MAX_MS);

  typedef enum logic [1:0] {IDLE, WAIT, GO, SHOW} state_t;

  state_t        state, state_nx;
  logic          tick_q, start_q, react_q;
  logic          tick, start_p, react_p;
  logic [15:0]   lfsr;
  logic [DW-1:0] delay, delay_nx;
  logic [13:0]   count, count_nx, result, result_nx;
  logic          fs, fs_nx, ovf, ovf_nx, rv, rv_nx;

  // tick_in is a divider output: both edges mark one millisecond
  assign tick    = bus.tick_in ^ tick_q;
  assign start_p = bus.start_btn & ~start_q;
  assign react_p = bus.react_btn & ~react_q;

  always_ff @(posedge cin) begin
    if (rst) begin
      tick_q  <= bus.tick_in;
      start_q <= bus.start_btn;
      react_q <= bus.react_btn;
      lfsr    <= LFSR_SEED;
      state   <= IDLE;
      delay   <= '0;
      count   <= '0;
      result  <= '0;
      fs      <= 1'b0;
      ovf     <= 1'b0;
      rv      <= 1'b0;
    end else begin
      tick_q  <= bus.tick_in;
      start_q <= bus.start_btn;
      react_q <= bus.react_btn;
      lfsr    <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      state   <= state_nx;
      delay   <= delay_nx;
      count   <= count_nx;
      result  <= result_nx;
      fs      <= fs_nx;
      ovf     <= ovf_nx;
      rv      <= rv_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    delay_nx  = delay;
    count_nx  = count;
    result_nx = result;
    fs_nx     = fs;
    ovf_nx    = ovf;
    rv_nx     = 1'b0;
    case (state)
      IDLE: if (start_p) begin
        state_nx = WAIT;
        delay_nx = DW'(MIN_DELAY_TICKS) + DW'(lfsr[DELAY_BITS-1:0]);
        count_nx = '0;
        fs_nx    = 1'b0;
        ovf_nx   = 1'b0;
      end
      // a react press beats a simultaneous GO transition
      WAIT: if (react_p) begin
        state_nx = IDLE;
        fs_nx    = 1'b1;
      end else if (tick) begin
        if (delay == '0) begin
          state_nx = GO;
          count_nx = '0;
        end else begin
          delay_nx = delay - 1'b1;
        end
      end
      // a tick landing with the press still counts toward the result
      GO: if (react_p) begin
        state_nx  = SHOW;
        result_nx = (tick && count != MAX_C) ? count + 14'd1 : count;
      end else if (tick) begin
        if (count >= MAX_C - 14'd1) begin
          state_nx  = SHOW;
          count_nx  = MAX_C;
          result_nx = MAX_C;
          ovf_nx    = 1'b1;
        end else begin
          count_nx = count + 14'd1;
        end
      end
      SHOW: begin
        rv_nx    = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.led_go       = (state == GO);
  assign bus.busy         = (state == WAIT) || (state == GO);
  assign bus.result_ms    = result;
  assign bus.result_valid = rv;
  assign bus.false_start  = fs;
  assign bus.overflow     = ovf;

`ifdef BEST_SCORE_EN
  logic [13:0] best;

  always_ff @(posedge cin) begin
    if (rst)
      best <= MAX_C;
    else if (state == SHOW && !ovf && result < best)
      best <= result;
  end

  assign bus.best_ms = best;
`else
  assign bus.best_ms = MAX_C;
`endif

endmodule
